cpu_fetch_queue: RTL
====================

# cpu_fetch_queue

Parametrised instruction-fetch stage with a prefetch queue, placed between the instruction cache or bus port and the decode stage. It fetches sequential 32-bit words ahead of decode into a QUEUE_DEPTH-entry FIFO, numbers each fetched instruction with a wrapping tag, and follows JAL targets locally. It halts after B-type/JALR instructions until the matching tagged redirect arrives. A flush input supports traps and exceptions.

## Interface
- QUEUE_DEPTH, 4, queue entries; power of two, ≥2
- TAG_WIDTH, 8, width of instruction tag
- RESET_PC, 32'h0000_0000, first fetch address after reset
- JAL_FOLLOW, 1, 1: JAL target computed locally, no wait; 0: JAL waits like a branch
- i_clock  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- o_bus_request  out  1  fetch request; held until i_bus_ready
- i_bus_ready  in  1  word available on i_bus_rdata this cycle
- o_bus_address  out  32  fetch address; word aligned
- i_bus_rdata  in  32  fetched instruction
- i_tag  in  TAG_WIDTH  tag of the resolved control-flow instruction
- i_pc_next  in  32  resolved next PC for i_tag
- i_flush  in  1  discard queue and restart at i_flush_pc
- i_flush_pc  in  32  restart address
- o_valid  out  1  queue head valid
- i_ready  in  1  decode accepts head
- o_tag  out  TAG_WIDTH  head tag
- o_instruction  out  32  head instruction
- o_pc  out  32  head PC
- o_count  out  $clog2(QUEUE_DEPTH+1)  queue occupancy

## Operation
- Registers: pc, tag counter, queue (circular, head/tail pointers plus count), wait_tag, and state ∈ {FETCH, WAIT, DRAIN}.
- FETCH: o_bus_request=1 when count < QUEUE_DEPTH, or when a request is already outstanding. Once raised, the request and o_bus_address=pc stay constant until i_bus_ready.
- On i_bus_ready in FETCH:
  - tag counter +1, wrapping mod 2^TAG_WIDTH.
  - Enqueue {tag counter+1, rdata, pc}.
  - B-type (opcode 1100011), JALR (1100111), or JAL with JAL_FOLLOW=0: wait_tag ← new tag, pc ← pc+4, state ← WAIT.
  - JAL with JAL_FOLLOW=1: pc ← pc + sign-extended J-immediate, remain in FETCH.
  - Otherwise: pc ← pc+4.
- WAIT: no request. When i_tag == wait_tag: pc ← i_pc_next, state ← FETCH. A non-matching i_tag is ignored. i_tag is also ignored in FETCH.
- Pop: when o_valid && i_ready, the head advances. Push and pop in the same cycle leave count unchanged.
- Flush (highest priority, any state):
  - Queue emptied (count=0), pc ← i_flush_pc.
  - If a request is outstanding without i_bus_ready in the same cycle: state ← DRAIN, and the request stays asserted at the old address.
  - Otherwise: state ← FETCH.
  - DRAIN: the word returned on i_bus_ready is discarded and the tag counter does not advance; then state ← FETCH.
  - Tag counter is never reset by flush.
- Address arithmetic is mod 2^32; pc wraps silently.

## Timing
- Reset (async assert, sync release): state=FETCH, pc=RESET_PC, tag counter=0, count=0, o_valid=0, o_tag=0, o_instruction=0, o_pc=0, o_bus_request=0.
- First o_bus_request: the first clock edge after reset release.
- Latency: i_bus_ready in cycle N → entry visible (o_valid=1 if previously empty) in cycle N+1.
- Back-to-back: new address is presented in cycle N+1, giving 1 word/cycle with a zero-wait bus.
- Full: the request is not raised; it is raised again in the cycle after the pop that makes count < QUEUE_DEPTH.
- Redirect: i_tag match in cycle N → request at i_pc_next in cycle N+1.
- Flush in cycle N: o_valid=0 in cycle N+1. Fetch from i_flush_pc starts in N+1, or one cycle after drain completes.
- Simultaneous i_flush and i_bus_ready: the word is discarded and the tag is not incremented.
- Simultaneous i_flush and pop: flush wins.

## Test plan
- Reset, zero-wait bus, i_ready=1, straight-line NOPs (32'h00000013) → tags 1,2,3…, o_pc 0,4,8…, one per cycle after a 2-cycle start.
- i_ready=0, QUEUE_DEPTH=4 → count saturates at 4, o_bus_request=0. Single pop → request resumes the next cycle at pc=16.
- BEQ at pc=8 (tag 3) → request stops. i_tag=2 is ignored. i_tag=3 with i_pc_next=0x40 → next o_pc=0x40, tag 4.
- JAL x0,+0x100 at pc=0 with JAL_FOLLOW=1 → next fetch at 0x100 with no stall. With JAL_FOLLOW=0 → waits for i_tag=1.
- Bus with 3-cycle latency; i_flush (i_flush_pc=0x200) asserted mid-request → old word discarded, tag not incremented, next queued o_pc=0x200.
- Tag wrap: 256 instructions with TAG_WIDTH=8 → tag sequence 255, 0, 1. A branch at tag 0 is released by i_tag=0.

Source files
------------

// File: rtl/cpu_fetch_queue.sv
// Instruction-fetch stage with a tagged prefetch FIFO between the bus port and decode.
// Follows JAL locally, stalls on branches/JALR until the matching tagged redirect, supports flush.
module cpu_fetch_queue #(
   parameter int          QUEUE_DEPTH = 4,
   parameter int          TAG_WIDTH   = 8,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter bit          JAL_FOLLOW  = 1'b1
) (
   input  logic                             i_clock,
   input  logic                             i_reset_n,
   output logic                             o_bus_request,
   input  logic                             i_bus_ready,
   output logic [31:0]                      o_bus_address,
   input  logic [31:0]                      i_bus_rdata,
   input  logic [TAG_WIDTH-1:0]             i_tag,
   input  logic [31:0]                      i_pc_next,
   input  logic                             i_flush,
   input  logic [31:0]                      i_flush_pc,
   output logic                             o_valid,
   input  logic                             i_ready,
   output logic [TAG_WIDTH-1:0]             o_tag,
   output logic [31:0]                      o_instruction,
   output logic [31:0]                      o_pc,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0] o_count
);

   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = $clog2(QUEUE_DEPTH+1);

   typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_DRAIN} state_t;

   state_t               state, state_next;
   logic [31:0]          pc, pc_next, drain_addr;
   logic [TAG_WIDTH-1:0] tag_count, wait_tag, new_tag;
   logic                 started;
   logic [PW-1:0]        head, tail;
   logic [CW-1:0]        count;

   logic [TAG_WIDTH-1:0] tag_mem   [QUEUE_DEPTH];
   logic [31:0]          instr_mem [QUEUE_DEPTH];
   logic [31:0]          pc_mem    [QUEUE_DEPTH];

   logic        accept, push, pop, is_stall, is_jal_follow;
   logic [6:0]  opcode;
   logic [31:0] jal_imm;

   // A draining request keeps the pre-flush address until the bus answers it.
   assign o_bus_request = started && ((state == ST_FETCH && count < CW'(QUEUE_DEPTH)) ||
                                      state == ST_DRAIN);
   assign o_bus_address = (state == ST_DRAIN) ? drain_addr : pc;

   assign accept  = o_bus_request && i_bus_ready;
   assign push    = accept && state == ST_FETCH && !i_flush;
   assign pop     = o_valid && i_ready && !i_flush;
   assign new_tag = tag_count + TAG_WIDTH'(1);

   assign opcode        = i_bus_rdata[6:0];
   assign jal_imm       = {{11{i_bus_rdata[31]}}, i_bus_rdata[31], i_bus_rdata[19:12],
                           i_bus_rdata[20], i_bus_rdata[30:21], 1'b0};
   assign is_stall      = opcode == 7'b1100011 || opcode == 7'b1100111 ||
                          (opcode == 7'b1101111 && !JAL_FOLLOW);
   assign is_jal_follow = opcode == 7'b1101111 && JAL_FOLLOW;

   always_comb begin
      state_next = state;
      pc_next    = pc;
      if (i_flush) begin
         pc_next    = i_flush_pc;
         state_next = (o_bus_request && !i_bus_ready) ? ST_DRAIN : ST_FETCH;
      end else begin
         case (state)
            ST_FETCH: begin
               if (accept) begin
                  if (is_stall) begin
                     pc_next    = pc + 32'd4;
                     state_next = ST_WAIT;
                  end else if (is_jal_follow) begin
                     pc_next = pc + jal_imm;
                  end else begin
                     pc_next = pc + 32'd4;
                  end
               end
            end
            ST_WAIT: begin
               if (i_tag == wait_tag) begin
                  pc_next    = i_pc_next;
                  state_next = ST_FETCH;
               end
            end
            ST_DRAIN: begin
               if (accept) state_next = ST_FETCH;
            end
            default: state_next = ST_FETCH;
         endcase
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state      <= ST_FETCH;
         pc         <= RESET_PC;
         drain_addr <= '0;
         tag_count  <= '0;
         wait_tag   <= '0;
         started    <= 1'b0;
         head       <= '0;
         tail       <= '0;
         count      <= '0;
      end else begin
         started <= 1'b1;
         state   <= state_next;
         pc      <= pc_next;
         if (i_flush && o_bus_request && !i_bus_ready) drain_addr <= o_bus_address;
         if (push) begin
            tag_count <= new_tag;
            if (is_stall) wait_tag <= new_tag;
         end
         // Flush beats any concurrent push or pop.
         if (i_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (push) begin
         tag_mem[tail]   <= new_tag;
         instr_mem[tail] <= i_bus_rdata;
         pc_mem[tail]    <= pc;
      end
   end

   assign o_valid       = (count != '0);
   assign o_count       = count;
   assign o_tag         = o_valid ? tag_mem[head]   : '0;
   assign o_instruction = o_valid ? instr_mem[head] : '0;
   assign o_pc          = o_valid ? pc_mem[head]    : '0;

endmodule
